fadd_seq: RTL and testbench
===========================

FADD_SEQ -- requirements
Module: fadd_seq

Interface
REQ-001 The block SHALL have parameter EXP_W, default 8, meaning exponent field width.
REQ-002 The block SHALL have parameter MAN_W, default 23, meaning stored mantissa (fraction) width; word width W = 1+EXP_W+MAN_W.
REQ-003 The block SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-004 The block SHALL have port RSTN  in  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port in_valid  in  1  operand pair offered.
REQ-006 The block SHALL have port in_ready  out  1  block can accept operands.
REQ-007 The block SHALL have port op  in  1  0 = a+b, 1 = a-b.
REQ-008 The block SHALL have ports a, b  in  W  IEEE-754-style operands {sign, exp, frac}.
REQ-009 The block SHALL have port out_valid  out  1  result available.
REQ-010 The block SHALL have port out_ready  in  1  consumer takes result.
REQ-011 The block SHALL have port result  out  W  sum/difference.
REQ-012 The block SHALL have port flags  out  3  {invalid, overflow, underflow}, valid with out_valid.

Function
REQ-013 in_ready SHALL be 1 only in state IDLE; operands, op captured on the cycle in_valid && in_ready.
REQ-014 FSM states SHALL be IDLE, ALIGN, ADD, NORM, ROUND, DONE; each non-IDLE/non-DONE state lasts exactly one cycle.
REQ-015 Latency SHALL be fixed: out_valid rises 5 cycles after the capture edge, independent of data.
REQ-016 ALIGN SHALL swap so the larger magnitude is first and right-shift the smaller significand by the exponent difference, saturating at MAN_W+3, with sticky OR of shifted-out bits.
REQ-017 ADD SHALL add or subtract significands (effective op = op XOR sign_a XOR sign_b) in MAN_W+4 bits incl. guard/round/sticky.
REQ-018 NORM SHALL normalise in one cycle using a leading-zero count; carry-out shifts right by one and increments exponent.
REQ-019 Exact zero result SHALL be +0, except (-x)+(-y) zero cases which yield -0.
REQ-020 Subnormal inputs SHALL be treated as zero; a result exponent below 1 SHALL flush to signed zero and set underflow.
REQ-021 Result exponent reaching all-ones SHALL produce signed infinity and set overflow.
REQ-022 Any NaN input, or inf-inf effective subtraction, SHALL produce canonical NaN {0, all-ones, 1 then zeros} and set invalid; inf op finite SHALL return that inf, no flag.
REQ-023 DONE SHALL hold out_valid, result, flags stable until out_ready=1, then return to IDLE next cycle; out_ready ignored outside DONE.
REQ-024 in_valid while busy SHALL be ignored (no queueing).

Reset
REQ-025 RSTN low SHALL asynchronously force state IDLE, in_ready=1 after release, out_valid=0, result=0, flags=0.
REQ-026 Reset mid-operation SHALL abandon the operation with no out_valid pulse.

Configuration
REQ-027 With FADD_RNE_EN defined, ROUND SHALL apply round-to-nearest-even using guard/round/sticky, renormalising on mantissa carry.
REQ-028 Without FADD_RNE_EN, ROUND SHALL truncate; latency unchanged (ROUND state kept).

Structure
REQ-029 Package fadd_pkg SHALL hold the state enum, flag bit indices and canonical-NaN/field-extract constants as functions of EXP_W/MAN_W.
REQ-030 Leading-zero count SHALL be sub-module fadd_lzc, parametrised by width, combinational.

Verification (EXP_W=8, MAN_W=23)
REQ-031 a=0x3F800000, b=0x3F800000, op=0 -> result 0x40000000, flags 0, out_valid 5 cycles after capture.
REQ-032 a=0x3FC00000, b=0x3FC00000, op=1 -> 0x00000000; a=0x7F7FFFFF+b=0x7F7FFFFF -> 0x7F800000, overflow=1.
REQ-033 a=0x7F800000, b=0x7F800000, op=1 -> 0x7FC00000, invalid=1; a=0x7FC00001 any b -> 0x7FC00000, invalid=1.
REQ-034 a=0x3F800000, b=0x33C00000 -> 0x3F800001 with FADD_RNE_EN, 0x3F800000 without; b=0x33800000 -> 0x3F800000 both.
REQ-035 out_ready held 0 for 10 cycles in DONE -> result/flags stable, in_ready=0, second in_valid ignored; then accepted after return to IDLE.
REQ-036 RSTN pulsed low during NORM -> out_valid stays 0, in_ready=1 after release, next operation correct.

Source files
------------

// File: rtl/fadd_pkg.sv
// Shared types and constants for the sequential floating-point adder.
// Field and NaN helpers take the exponent/fraction widths as arguments.
package fadd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    ADD,
    NORM,
    ROUND,
    DONE
  } state_t;

  localparam int FLAG_INV = 2;
  localparam int FLAG_OVF = 1;
  localparam int FLAG_UNF = 0;

  function automatic int sign_bit(int ew, int mw);
    return ew + mw;
  endfunction

  function automatic int exp_lsb(int mw);
    return mw;
  endfunction

  function automatic logic [63:0] exp_ones(int ew);
    return (64'd1 << ew) - 64'd1;
  endfunction

  function automatic logic [63:0] qnan_word(int ew, int mw);
    logic [63:0] v;
    v = exp_ones(ew) << exp_lsb(mw);
    v = v | (64'd1 << (mw - 1));
    return v;
  endfunction

endpackage

// File: rtl/fadd_lzc.sv
// Combinational leading-zero counter; an all-zero input yields W.
module fadd_lzc #(
  parameter int W  = 27,
  parameter int LW = $clog2(W + 1)
) (
  input  logic [W-1:0]  vec,
  output logic [LW-1:0] cnt
);

  always_comb begin
    cnt = LW'(W);
    for (int i = 0; i < W; i++) begin
      if (vec[i]) cnt = LW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/fadd_seq.sv
// Multi-cycle IEEE-style adder/subtractor: IDLE-ALIGN-ADD-NORM-ROUND-DONE.
// Define FADD_RNE_EN for round-to-nearest-even; otherwise ROUND truncates.
module fadd_seq
  import fadd_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                     clk,
  input  logic                     RSTN,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     op,
  input  logic [EXP_W+MAN_W:0]     a,
  input  logic [EXP_W+MAN_W:0]     b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     result,
  output logic [2:0]               flags
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int SW = MAN_W + 4;
  localparam int XW = EXP_W + 2;
  localparam int LW = $clog2(SW + 1);
  localparam int SB = sign_bit(EXP_W, MAN_W);
  localparam int EL = exp_lsb(MAN_W);

  localparam logic [W-1:0]     QNAN  = W'(qnan_word(EXP_W, MAN_W));
  localparam logic [EXP_W-1:0] EMAX  = EXP_W'(exp_ones(EXP_W));
  localparam logic [EXP_W-1:0] SHMAX = EXP_W'(MAN_W + 3);

  state_t state_q, state_d;

  logic [W-1:0]           a_q, b_q;
  logic                   op_q;
  logic [SW-1:0]          big_q, sml_q;
  logic signed [XW-1:0]   exp_q;
  logic                   sign_q, sub_q, zsign_q;
  logic                   spec_q, inv_q;
  logic [W-1:0]           sval_q;
  logic [SW:0]            sum_q;
  logic [SW-1:0]          nsig_q;
  logic signed [XW-1:0]   nexp_q;
  logic                   nzero_q;
  logic [W-1:0]           result_q;
  logic [2:0]             flags_q;

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = ALIGN;
      ALIGN:   state_d = ADD;
      ADD:     state_d = NORM;
      NORM:    state_d = ROUND;
      ROUND:   state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    result    = result_q;
    flags     = flags_q;
  end

  logic                 sa, sb, swap;
  logic                 a_nan, b_nan, a_inf, b_inf;
  logic [EXP_W-1:0]     ea, eb, ebig, esml, dexp, sh;
  logic [W-2:0]         ka, kb, kbig, ksml;
  logic [SW-1:0]        sbig, ssml, sshf, slost;
  logic                 spec_d, inv_d;
  logic [W-1:0]         sval_d;

  // Subnormals collapse to zero via the magnitude key.
  always_comb begin
    sa    = a_q[SB];
    sb    = b_q[SB] ^ op_q;
    ea    = a_q[W-2:EL];
    eb    = b_q[W-2:EL];
    a_nan = (ea == EMAX) && (a_q[MAN_W-1:0] != '0);
    b_nan = (eb == EMAX) && (b_q[MAN_W-1:0] != '0);
    a_inf = (ea == EMAX) && (a_q[MAN_W-1:0] == '0);
    b_inf = (eb == EMAX) && (b_q[MAN_W-1:0] == '0);
    ka    = (ea == '0) ? '0 : a_q[W-2:0];
    kb    = (eb == '0) ? '0 : b_q[W-2:0];
    swap  = (kb > ka);
    kbig  = swap ? kb : ka;
    ksml  = swap ? ka : kb;
    ebig  = kbig[W-2:EL];
    esml  = ksml[W-2:EL];
    dexp  = ebig - esml;
    sh    = (dexp > SHMAX) ? SHMAX : dexp;
    sbig  = {(ebig != '0), kbig[MAN_W-1:0], 3'b000};
    ssml  = {(esml != '0), ksml[MAN_W-1:0], 3'b000};
    sshf  = ssml >> sh;
    slost = ssml & ~({SW{1'b1}} << sh);
    spec_d = 1'b1;
    inv_d  = 1'b0;
    sval_d = '0;
    if (a_nan || b_nan) begin
      inv_d  = 1'b1;
      sval_d = QNAN;
    end else if (a_inf && b_inf) begin
      inv_d  = (sa != sb);
      sval_d = (sa != sb) ? QNAN : {sa, EMAX, {MAN_W{1'b0}}};
    end else if (a_inf) begin
      sval_d = {sa, EMAX, {MAN_W{1'b0}}};
    end else if (b_inf) begin
      sval_d = {sb, EMAX, {MAN_W{1'b0}}};
    end else begin
      spec_d = 1'b0;
    end
  end

  logic [LW-1:0] lz;

  fadd_lzc #(
    .W (SW),
    .LW(LW)
  ) u_lzc (
    .vec(sum_q[SW-1:0]),
    .cnt(lz)
  );

  logic [MAN_W+1:0]     mant;
  logic signed [XW-1:0] rexp;
  logic [MAN_W-1:0]     rfrac;
  logic                 inc;
  logic [W-1:0]         res_d;
  logic [2:0]           flg_d;

`ifdef FADD_RNE_EN
  assign inc = nsig_q[2] & (nsig_q[1] | nsig_q[0] | nsig_q[3]);
`else
  logic unused_grs;
  assign unused_grs = ^nsig_q[2:0];
  assign inc = 1'b0;
`endif

  always_comb begin
    mant  = {1'b0, nsig_q[SW-1:3]} + {{(MAN_W+1){1'b0}}, inc};
    rexp  = nexp_q + {{(XW-1){1'b0}}, mant[MAN_W+1]};
    rfrac = mant[MAN_W+1] ? mant[MAN_W:1] : mant[MAN_W-1:0];
    res_d = '0;
    flg_d = '0;
    if (spec_q) begin
      res_d           = sval_q;
      flg_d[FLAG_INV] = inv_q;
    end else if (nzero_q) begin
      res_d = {zsign_q, {(W-1){1'b0}}};
    end else if ($signed(rexp) >= $signed({2'b00, EMAX})) begin
      res_d           = {sign_q, EMAX, {MAN_W{1'b0}}};
      flg_d[FLAG_OVF] = 1'b1;
    end else if ($signed(rexp) < $signed(XW'(1))) begin
      res_d           = {sign_q, {(W-1){1'b0}}};
      flg_d[FLAG_UNF] = 1'b1;
    end else begin
      res_d = {sign_q, rexp[EXP_W-1:0], rfrac};
    end
  end

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= 1'b0;
      big_q    <= '0;
      sml_q    <= '0;
      exp_q    <= '0;
      sign_q   <= 1'b0;
      sub_q    <= 1'b0;
      zsign_q  <= 1'b0;
      spec_q   <= 1'b0;
      inv_q    <= 1'b0;
      sval_q   <= '0;
      sum_q    <= '0;
      nsig_q   <= '0;
      nexp_q   <= '0;
      nzero_q  <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      if (in_valid && in_ready) begin
        a_q  <= a;
        b_q  <= b;
        op_q <= op;
      end
      if (state_q == ALIGN) begin
        big_q   <= sbig;
        sml_q   <= {sshf[SW-1:1], sshf[0] | (|slost)};
        exp_q   <= {2'b00, ebig};
        sign_q  <= swap ? sb : sa;
        sub_q   <= sa ^ sb;
        zsign_q <= sa & sb;
        spec_q  <= spec_d;
        inv_q   <= inv_d;
        sval_q  <= sval_d;
      end
      if (state_q == ADD) begin
        sum_q <= sub_q ? {1'b0, big_q} - {1'b0, sml_q}
                       : {1'b0, big_q} + {1'b0, sml_q};
      end
      if (state_q == NORM) begin
        nzero_q <= (sum_q == '0);
        if (sum_q[SW]) begin
          nsig_q <= {sum_q[SW:2], sum_q[1] | sum_q[0]};
          nexp_q <= exp_q + XW'(1);
        end else begin
          nsig_q <= sum_q[SW-1:0] << lz;
          nexp_q <= exp_q - XW'(lz);
        end
      end
      if (state_q == ROUND) begin
        result_q <= res_d;
        flags_q  <= flg_d;
      end
    end
  end

endmodule

// File: tb/tb_fadd_seq.sv
// Directed self-checking bench for fadd_seq (EXP_W=8, MAN_W=23).
module tb_fadd_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         RSTN;
  logic         in_valid;
  logic         in_ready;
  logic         op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [2:0]   flags;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         op;
    logic [W-1:0] r;
    logic [2:0]   f;
  } vec_t;

  fadd_seq #(
    .EXP_W(8),
    .MAN_W(23)
  ) dut (
    .clk      (clk),
    .RSTN     (RSTN),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .flags    (flags)
  );

  always #5 clk = ~clk;

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic top, output logic [W-1:0] res,
                        output logic [2:0] flg, output int lat);
    lat = 0;
    res = 'x;
    flg = 'x;
    for (int i = 0; i < 20 && !in_ready; i++) begin
      @(posedge clk);
      #1;
    end
    a = ta;
    b = tb;
    op = top;
    out_ready = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 30) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (out_valid) begin
      res = result;
      flg = flags;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    RSTN = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    op = 1'b0;
    a = '0;
    b = '0;
    #12;
    checks++;
    if (out_valid !== 1'b0 || result !== '0 || flags !== 3'b000) begin
      failures++;
      $display("FAIL reset_out: out_valid=%b result=%h flags=%b want 0/0/0",
               out_valid, result, flags);
    end
    @(negedge clk);
    RSTN = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: in_ready=%b want 1", in_ready);
    end
  endtask

  task automatic test_latency;
    logic [W-1:0] r;
    logic [2:0]   f;
    int           lat;
    run_op(32'h3F800000, 32'h3F800000, 1'b0, r, f, lat);
    checks++;
    if (lat !== 5) begin
      failures++;
      $display("FAIL latency: got %0d cycles want 5", lat);
    end
    checks++;
    if (r !== 32'h40000000) begin
      failures++;
      $display("FAIL one_plus_one: result=%h want 40000000", r);
    end
    checks++;
    if (f !== 3'b000) begin
      failures++;
      $display("FAIL one_plus_one_flags: flags=%b want 000", f);
    end
  endtask

  task automatic test_arith;
    vec_t         v[12];
    logic [W-1:0] r;
    logic [2:0]   f;
    int           lat;
    v[0]  = '{32'h3FC00000, 32'h3FC00000, 1'b1, 32'h00000000, 3'b000};
    v[1]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b010};
    v[2]  = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b100};
    v[3]  = '{32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b100};
    v[4]  = '{32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 3'b000};
    v[5]  = '{32'h3F800000, 32'h7F800000, 1'b0, 32'h7F800000, 3'b000};
    v[6]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000};
    v[7]  = '{32'hBF800000, 32'hBF800000, 1'b1, 32'h00000000, 3'b000};
    v[8]  = '{32'h3F800000, 32'h3F400000, 1'b1, 32'h3E800000, 3'b000};
    v[9]  = '{32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 3'b001};
    v[10] = '{32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 3'b000};
    v[11] = '{32'h40000000, 32'h3F800000, 1'b0, 32'h40400000, 3'b000};
    for (int i = 0; i < 12; i++) begin
      run_op(v[i].a, v[i].b, v[i].op, r, f, lat);
      checks++;
      if (r !== v[i].r) begin
        failures++;
        $display("FAIL arith[%0d] result: got %h want %h", i, r, v[i].r);
      end
      checks++;
      if (f !== v[i].f) begin
        failures++;
        $display("FAIL arith[%0d] flags: got %b want %b", i, f, v[i].f);
      end
    end
  endtask

  task automatic test_round;
    logic [W-1:0] r;
    logic [2:0]   f;
    logic [W-1:0] want;
    int           lat;
`ifdef FADD_RNE_EN
    want = 32'h3F800001;
`else
    want = 32'h3F800000;
`endif
    run_op(32'h3F800000, 32'h33C00000, 1'b0, r, f, lat);
    checks++;
    if (r !== want) begin
      failures++;
      $display("FAIL round_above_half: got %h want %h", r, want);
    end
    run_op(32'h3F800000, 32'h33800000, 1'b0, r, f, lat);
    checks++;
    if (r !== 32'h3F800000) begin
      failures++;
      $display("FAIL round_tie_even: got %h want 3F800000", r);
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] r;
    logic [2:0]   f;
    int           lat;
    a = 32'h40000000;
    b = 32'h3F800000;
    op = 1'b0;
    out_ready = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int i = 0; i < 20 && !out_valid; i++) begin
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (out_valid !== 1'b1 || result !== 32'h40400000 || flags !== 3'b000) begin
        failures++;
        $display("FAIL stall_hold[%0d]: valid=%b result=%h flags=%b want 1/40400000/000",
                 i, out_valid, result, flags);
      end
      checks++;
      if (in_ready !== 1'b0) begin
        failures++;
        $display("FAIL stall_ready[%0d]: in_ready=%b want 0", i, in_ready);
      end
      if (i == 2) begin
        a = 32'h3F800000;
        b = 32'h3F800000;
        in_valid = 1'b1;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL stall_release: in_ready=%b out_valid=%b want 1/0",
               in_ready, out_valid);
    end
    run_op(32'h3F800000, 32'h3F800000, 1'b0, r, f, lat);
    checks++;
    if (r !== 32'h40000000) begin
      failures++;
      $display("FAIL after_stall: got %h want 40000000", r);
    end
  endtask

  task automatic test_reset_mid;
    logic [W-1:0] r;
    logic [2:0]   f;
    logic         seen;
    int           lat;
    a = 32'h40000000;
    b = 32'h3F800000;
    op = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    RSTN = 1'b0;
    #2;
    seen = out_valid;
    @(negedge clk);
    RSTN = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_valid: out_valid seen=%b want 0", seen);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_ready: in_ready=%b want 1", in_ready);
    end
    run_op(32'h40000000, 32'h3F800000, 1'b1, r, f, lat);
    checks++;
    if (r !== 32'h3F800000 || f !== 3'b000) begin
      failures++;
      $display("FAIL reset_mid_next: got %h/%b want 3F800000/000", r, f);
    end
  endtask

  initial begin
    test_reset;
    test_latency;
    test_arith;
    test_round;
    test_back_to_back;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
